// File: rtl/zktc_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zktc_gpio_pkg
// Description : Register offsets and bus width shared by the zktc GPIO input
//               capture peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package zktc_gpio_pkg;

  localparam int GPIO_BUS_W = 16;

  localparam logic [1:0] GPIO_DATA    = 2'd0;
  localparam logic [1:0] GPIO_RISE_EN = 2'd1;
  localparam logic [1:0] GPIO_FALL_EN = 2'd2;
  localparam logic [1:0] GPIO_PEND    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/zktc_gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : zktc_gpio_debounce
// Description : Single-pin debouncer from synchroniser output to `stable`.
//               Built only when ZKTC_GPIO_DEBOUNCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef ZKTC_GPIO_DEBOUNCE_EN
module zktc_gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  input  logic sync_in,
  output logic stable
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  // load seeds the level on arming so a pin idling high is not seen as a rise
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (load) begin
      stable_d = sync_in;
      cnt_d    = '0;
    end else if (en) begin
      if (sync_in == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync_in;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule
`endif
`default_nettype wire

// File: rtl/zktc_gpio_in.sv
`default_nettype none
// ============================================================================
// Module      : zktc_gpio_in
// Description : GPIO input capture: synchronise, optional debounce
//               (ZKTC_GPIO_DEBOUNCE_EN), edge detect into W1C PEND, level irq.
// Revision    : 1.0 - initial release
// ============================================================================
module zktc_gpio_in
  import zktc_gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WIDTH-1:0]      io_in,
  input  logic [1:0]            addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [GPIO_BUS_W-1:0] wdata,
  output logic [GPIO_BUS_W-1:0] rdata,
  output logic                  irq
);

  logic [WIDTH-1:0]      sync1_q,   sync1_d;
  logic [WIDTH-1:0]      sync2_q,   sync2_d;
  logic [1:0]            fill_q,    fill_d;
  logic                  armed_q,   armed_d;
  logic [WIDTH-1:0]      prev_q,    prev_d;
  logic [WIDTH-1:0]      rise_en_q, rise_en_d;
  logic [WIDTH-1:0]      fall_en_q, fall_en_d;
  logic [WIDTH-1:0]      pend_q,    pend_d;
  logic [GPIO_BUS_W-1:0] rdata_q,   rdata_d;

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_valid;
  logic             w_arm_load;
  logic             w_unused_wdata;

  assign w_unused_wdata = ^wdata;

`ifdef ZKTC_GPIO_DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    zktc_gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rstn   (rstn),
      .load   (w_arm_load),
      .en     (armed_q),
      .sync_in(sync2_q[gi]),
      .stable (w_stable[gi])
    );
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign w_stable = sync2_q;
`endif

  // The synchroniser holds real pin data once two edges have passed since reset
  assign w_valid    = (fill_q == 2'd2);
  assign w_arm_load = w_valid & ~armed_q;

  always_comb begin
    sync1_d   = io_in;
    sync2_d   = sync1_q;
    fill_d    = w_valid ? fill_q : fill_q + 2'd1;
    armed_d   = armed_q | w_valid;
    prev_d    = w_arm_load ? sync2_q : w_stable;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w_clr     = '0;
    w_set     = '0;
    rdata_d   = rdata_q;

    if (armed_q) begin
      w_set = ((w_stable & ~prev_q) & rise_en_q) | ((~w_stable & prev_q) & fall_en_q);
    end

    if (we) begin
      case (addr)
        GPIO_RISE_EN: rise_en_d = wdata[WIDTH-1:0];
        GPIO_FALL_EN: fall_en_d = wdata[WIDTH-1:0];
        GPIO_PEND:    w_clr     = wdata[WIDTH-1:0];
        default:      ;
      endcase
    end

    // Set is applied after clear so a coincident new edge survives the W1C
    pend_d = (pend_q & ~w_clr) | w_set;

    if (re) begin
      rdata_d = '0;
      case (addr)
        GPIO_DATA:    rdata_d[WIDTH-1:0] = w_stable;
        GPIO_RISE_EN: rdata_d[WIDTH-1:0] = rise_en_q;
        GPIO_FALL_EN: rdata_d[WIDTH-1:0] = fall_en_q;
        GPIO_PEND:    rdata_d[WIDTH-1:0] = pend_q;
        default:      rdata_d            = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      prev_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      prev_q    <= prev_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = |pend_q;

endmodule
`default_nettype wire

// File: tb/tb_zktc_gpio_in.sv
`default_nettype none
// ============================================================================
// Module      : tb_zktc_gpio_in
// Description : Self-checking bench for zktc_gpio_in (either debounce build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zktc_gpio_in;

  localparam int W  = 8;
  localparam int DB = 8;
`ifdef ZKTC_GPIO_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int SETTLE = DEB ? DB + 4 : 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [W-1:0]  io_in = '0;
  logic [1:0]    addr = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [15:0]   wdata = '0;
  logic [15:0]   rdata;
  logic          irq;

  zktc_gpio_in #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .io_in(io_in),
    .addr (addr),
    .we   (we),
    .re   (re),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-cycle history of pin samples and accepted levels
  int           t;
  logic [W-1:0] samp[$];
  logic [W-1:0] stab[$];
  logic [W-1:0] m_rise, m_fall, m_pend;
  logic [15:0]  m_rdata;
  logic [W-1:0] cur_io;

  typedef struct {
    logic [1:0]  a;
    bit          w;
    bit          r;
    logic [15:0] wd;
    bit          chk;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepted level in cycle n: raw sample two edges back, or with debounce a
  // level that has disagreed for DB consecutive armed cycles.
  function automatic logic [W-1:0] model_stable(input int n);
    logic [W-1:0] s;
    bit           all_diff;
    if (!DEB) return (n >= 2) ? samp[n-1] : '0;
    if (n < 3) return '0;
    if (n == 3) return samp[1];
    s = stab[n-1];
    if (n - DB >= 3) begin
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int c = n - DB; c <= n - 1; c++)
          if (samp[c-1][i] == stab[n-1][i]) all_diff = 1'b0;
        if (all_diff) s[i] = ~stab[n-1][i];
      end
    end
    return s;
  endfunction

  function automatic logic [W-1:0] model_set();
    logic [W-1:0] pv;
    if (t < 3) return '0;
    pv = (t == 3) ? samp[1] : stab[t-1];
    return ((stab[t] & ~pv) & m_rise) | ((~stab[t] & pv) & m_fall);
  endfunction

  task automatic step(input logic [1:0] a, input bit w, input bit r,
                      input logic [15:0] wd, input logic [W-1:0] io);
    logic [W-1:0] set, clr;
    addr = a; we = w; re = r; wdata = wd; io_in = io;
    @(posedge clk);
    set = model_set();
    if (r) begin
      case (a)
        2'd0: m_rdata = {8'h00, stab[t]};
        2'd1: m_rdata = {8'h00, m_rise};
        2'd2: m_rdata = {8'h00, m_fall};
        default: m_rdata = {8'h00, m_pend};
      endcase
    end
    clr = (w && a == 2'd3) ? wd[W-1:0] : '0;
    if (w && a == 2'd1) m_rise = wd[W-1:0];
    if (w && a == 2'd2) m_fall = wd[W-1:0];
    m_pend = (m_pend & ~clr) | set;
    samp.push_back(io);
    t++;
    stab.push_back(model_stable(t));
    #1;
    chk("rdata_model", rdata, m_rdata);
    chk("irq_model", {15'b0, irq}, {15'b0, |m_pend});
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b0, 16'h0, cur_io);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    step(a, 1'b1, 1'b0, d, cur_io);
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
    step(a, 1'b0, 1'b1, 16'h0, cur_io);
    chk(name, rdata, exp);
  endtask

  task automatic do_reset(input logic [W-1:0] io);
    rstn = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    io_in = io; cur_io = io;
    #1;
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_irq", {15'b0, irq}, 16'h0);
    repeat (2) @(negedge clk);
    t = 0;
    samp = {};
    stab = {};
    samp.push_back('0);
    stab.push_back('0);
    m_rise = '0; m_fall = '0; m_pend = '0; m_rdata = '0;
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    bit           found;
    logic [W-1:0] s;

    vecs[0]  = '{2'd1, 1'b1, 1'b0, 16'hA5C3, 1'b0, 16'h0000};
    vecs[1]  = '{2'd1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h00C3};
    vecs[2]  = '{2'd2, 1'b1, 1'b0, 16'hFF3C, 1'b0, 16'h0000};
    vecs[3]  = '{2'd2, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h003C};
    vecs[4]  = '{2'd0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000};
    vecs[5]  = '{2'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h005A};
    vecs[6]  = '{2'd1, 1'b1, 1'b1, 16'h0011, 1'b1, 16'h00C3};
    vecs[7]  = '{2'd1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0011};
    vecs[8]  = '{2'd3, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000};
    vecs[9]  = '{2'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{2'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h005A};
    vecs[11] = '{2'd2, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h005A};

    #2;
    // Pin 0 high through reset: DATA shows it, no spurious edge
    do_reset(8'h01);
    idle(10 + (DEB ? DB : 0));
    read_chk("data_after_reset", 2'd0, 16'h0001);
    read_chk("pend_after_reset", 2'd3, 16'h0000);
    chk("irq_after_reset", {15'b0, irq}, 16'h0);

    // Register access vectors with steady pins
    do_reset(8'h5A);
    idle(SETTLE);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].a, vecs[i].w, vecs[i].r, vecs[i].wd, cur_io);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

    // Rising edge on pin 1, then W1C
    do_reset(8'h01);
    idle(SETTLE);
    wr(2'd1, 16'h0002);
    cur_io = 8'h03;
    idle(SETTLE);
    chk("rise_irq", {15'b0, irq}, 16'h0001);
    read_chk("rise_pend", 2'd3, 16'h0002);
    wr(2'd3, 16'h0002);
    read_chk("w1c_pend", 2'd3, 16'h0000);
    chk("w1c_irq", {15'b0, irq}, 16'h0);

    // Falling edge on pin 0 only
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0001);
    cur_io = 8'h02;
    idle(SETTLE);
    read_chk("fall_pend", 2'd3, 16'h0001);
    cur_io = 8'h03;
    idle(SETTLE);
    read_chk("rise_ignored", 2'd3, 16'h0001);
    wr(2'd3, 16'h00FF);

    // W1C landing on the same edge as a new rise on pin 1
    wr(2'd1, 16'h0002);
    wr(2'd2, 16'h0000);
    cur_io = 8'h01;
    idle(SETTLE);
    wr(2'd3, 16'h00FF);
    cur_io = 8'h03;
    found = 1'b0;
    for (int k = 0; k < SETTLE + 4 && !found; k++) begin
      s = model_set();
      if (s[1]) begin
        found = 1'b1;
        step(2'd3, 1'b1, 1'b0, 16'h0002, cur_io);
      end else begin
        idle(1);
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL w1c_race_edge: got none expected rise");
    end
    read_chk("w1c_race_pend", 2'd3, 16'h0002);
    wr(2'd3, 16'h00FF);

    // Pin 2: glitch rejection (debounce only) and pin-to-DATA latency
    wr(2'd1, 16'h0004);
    cur_io = 8'h01;
    idle(SETTLE);
    wr(2'd3, 16'h00FF);
`ifdef ZKTC_GPIO_DEBOUNCE_EN
    cur_io = 8'h05;
    idle(5);
    cur_io = 8'h01;
    idle(SETTLE);
    read_chk("glitch_data", 2'd0, 16'h0001);
    read_chk("glitch_pend", 2'd3, 16'h0000);
`endif
    cur_io = 8'h05;
    lat = 0;
    for (int k = 1; k <= SETTLE + 4 && lat == 0; k++) begin
      step(2'd0, 1'b0, 1'b1, 16'h0, cur_io);
      if (rdata[2]) lat = k;
    end
    chk("pin_to_data_lat", 16'(lat), 16'(DEB ? DB + 3 : 3));

    // Reset with all bits pending, then re-arm with pins high
    wr(2'd1, 16'h00FF);
    wr(2'd2, 16'h00FF);
    cur_io = 8'h00;
    idle(SETTLE);
    wr(2'd3, 16'h00FF);
    cur_io = 8'hFF;
    idle(SETTLE);
    read_chk("pend_all", 2'd3, 16'h00FF);
    do_reset(8'hFF);
    read_chk("rearm_rise_en", 2'd1, 16'h0000);
    read_chk("rearm_pend0", 2'd3, 16'h0000);
    wr(2'd1, 16'h00FF);
    idle(SETTLE);
    read_chk("rearm_pend", 2'd3, 16'h0000);
    chk("rearm_irq", {15'b0, irq}, 16'h0);

    // Randomised bus traffic and pin activity against the model
    do_reset(W'($urandom));
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) cur_io = cur_io ^ W'($urandom);
      step(2'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           16'($urandom), cur_io);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
